// File: rtl/mul_defs.sv
// Shared defaults and FSM state encoding for the regfile-attached shift-add multiplier.
package mul_defs;
  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_AW    = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CALC  = 3'd2,
    S_WB_LO = 3'd3,
    S_WB_HI = 3'd4
  } state_t;
endpackage

// File: rtl/shift_add_core.sv
// Iterative unsigned shift-add datapath: one multiplier bit retired per step.
module shift_add_core
  import mul_defs::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_last
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [WIDTH:0]     w_sum;

  // Carry out of the upper-half add becomes the new MSB after the shift.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (i_step) begin
      r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end

  assign o_product = r_acc;
  assign o_last    = (r_count == LAST_CNT);
endmodule

// File: rtl/regfile_mul_unit.sv
// Multiplier that reads two operands from the register file and writes the product back.
module regfile_mul_unit
  import mul_defs::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    rs_a,
  input  logic [AW-1:0]    rs_b,
  input  logic [AW-1:0]    rd,
  input  logic             wide,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    raddra,
  output logic [AW-1:0]    raddrb,
  input  logic [WIDTH-1:0] douta,
  input  logic [WIDTH-1:0] doutb,
  output logic [AW-1:0]    waddr,
  output logic [WIDTH-1:0] din,
  output logic             we
);
  state_t             r_state;
  logic [AW-1:0]      r_rd;
  logic               r_wide;
  logic               r_busy;
  logic [AW-1:0]      r_raddra;
  logic [AW-1:0]      r_raddrb;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [2*WIDTH-1:0] w_product;

  assign w_load = (r_state == S_FETCH);
  assign w_step = (r_state == S_CALC);

  shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_a       (douta),
    .i_b       (doutb),
    .o_product (w_product),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rd     <= '0;
      r_wide   <= 1'b0;
      r_busy   <= 1'b0;
      r_raddra <= '0;
      r_raddrb <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rd     <= rd;
            r_wide   <= wide;
            r_raddra <= rs_a;
            r_raddrb <= rs_b;
            r_busy   <= 1'b1;
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_CALC;
        S_CALC: begin
          if (w_last) r_state <= S_WB_LO;
        end
        S_WB_LO: begin
          r_busy  <= r_wide;
          r_state <= r_wide ? S_WB_HI : S_IDLE;
        end
        S_WB_HI: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write port is decoded from state and the product register only, never from inputs.
  always_comb begin
    we    = 1'b0;
    done  = 1'b0;
    waddr = '0;
    din   = '0;
    case (r_state)
      S_WB_LO: begin
        we    = 1'b1;
        waddr = r_rd;
        din   = w_product[WIDTH-1:0];
        done  = ~r_wide;
      end
      S_WB_HI: begin
        we    = 1'b1;
        waddr = AW'(r_rd + 1'b1);
        din   = w_product[2*WIDTH-1:WIDTH];
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = r_busy;
  assign raddra = r_raddra;
  assign raddrb = r_raddrb;
endmodule

// File: tb/tb_regfile_mul_unit.sv
// Directed bench: behavioural regfile around regfile_mul_unit with hand-computed products.
module tb_regfile_mul_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  rs_a = '0, rs_b = '0, rd = '0;
  logic        wide = 1'b0;
  logic        busy, done, we;
  logic [3:0]  raddra, raddrb, waddr;
  logic [15:0] douta, doutb, din;

  logic [15:0] rf [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int          n_wr;
  int          busy_drop;
  bit          saw_done;
  int          wr_cyc  [4];
  logic [3:0]  wr_addr [4];
  logic [15:0] wr_din  [4];
  logic        wr_done [4];

  always #5 clk = ~clk;

  regfile_mul_unit #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .wide(wide),
    .busy(busy), .done(done), .raddra(raddra), .raddrb(raddrb),
    .douta(douta), .doutb(doutb), .waddr(waddr), .din(din), .we(we)
  );

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (we) rf[waddr] <= din;
  end
  assign douta = rf[raddra];
  assign doutb = rf[raddrb];

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    @(negedge clk);
  endtask

  // Starts an op and records every write until done (bounded); optionally re-asserts start mid-op.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic w, input int inj_cyc, input logic [3:0] inj_rd);
    n_wr = 0; busy_drop = 0; saw_done = 0;
    rs_a = a; rs_b = b; rd = d; wide = w; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 30 && !saw_done; cyc++) begin
      @(negedge clk);
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) rd = inj_rd;
      if (!busy) busy_drop++;
      if (we) begin
        if (n_wr < 4) begin
          wr_cyc[n_wr] = cyc; wr_addr[n_wr] = waddr; wr_din[n_wr] = din; wr_done[n_wr] = done;
        end
        n_wr++;
      end
      if (done) saw_done = 1;
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, we} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {busy, done, we});
    end
    n_checks++;
    if ({waddr, din, raddra, raddrb} !== 28'h0) begin
      n_fail++; $display("FAIL reset_addr: waddr=%h din=%h ra=%h rb=%h expected all 0", waddr, din, raddra, raddrb);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) preload(4'(i), 16'h0000);
  endtask

  task automatic test_narrow;
    preload(4'd0, 16'd3);
    preload(4'd1, 16'd5);
    run_op(4'd0, 4'd1, 4'd2, 1'b0, 0, 4'd0);
    n_checks++;
    if (!saw_done || n_wr != 1) begin
      n_fail++; $display("FAIL narrow_writes: done_seen=%0d writes=%0d expected 1/1", saw_done, n_wr);
    end else begin
      n_checks++;
      if (wr_cyc[0] != 18) begin
        n_fail++; $display("FAIL narrow_latency: we at cycle %0d expected 18", wr_cyc[0]);
      end
      n_checks++;
      if ({wr_addr[0], wr_din[0], wr_done[0]} !== {4'd2, 16'h000F, 1'b1}) begin
        n_fail++; $display("FAIL narrow_wb: waddr=%h din=%h done=%b expected 2 000f 1", wr_addr[0], wr_din[0], wr_done[0]);
      end
    end
    n_checks++;
    if (rf[2] !== 16'h000F) begin
      n_fail++; $display("FAIL narrow_r2: r2=%h expected 000f", rf[2]);
    end
    n_checks++;
    if (busy !== 1'b0 || busy_drop != 0) begin
      n_fail++; $display("FAIL narrow_busy: busy=%b drops=%0d expected 0/0", busy, busy_drop);
    end
  endtask

  task automatic test_wide;
    preload(4'd3, 16'hFFFF);
    run_op(4'd3, 4'd3, 4'd4, 1'b1, 0, 4'd0);
    n_checks++;
    if (n_wr != 2 || !saw_done) begin
      n_fail++; $display("FAIL wide_writes: writes=%0d done_seen=%0d expected 2/1", n_wr, saw_done);
    end else begin
      n_checks++;
      if ({wr_addr[0], wr_din[0], wr_done[0]} !== {4'd4, 16'h0001, 1'b0} || wr_cyc[0] != 18) begin
        n_fail++; $display("FAIL wide_lo: cyc=%0d waddr=%h din=%h done=%b expected 18 4 0001 0", wr_cyc[0], wr_addr[0], wr_din[0], wr_done[0]);
      end
      n_checks++;
      if ({wr_addr[1], wr_din[1], wr_done[1]} !== {4'd5, 16'hFFFE, 1'b1} || wr_cyc[1] != 19) begin
        n_fail++; $display("FAIL wide_hi: cyc=%0d waddr=%h din=%h done=%b expected 19 5 fffe 1", wr_cyc[1], wr_addr[1], wr_din[1], wr_done[1]);
      end
    end
    n_checks++;
    if ({rf[4], rf[5]} !== {16'h0001, 16'hFFFE}) begin
      n_fail++; $display("FAIL wide_rf: r4=%h r5=%h expected 0001 fffe", rf[4], rf[5]);
    end
  endtask

  task automatic test_wrap;
    preload(4'd6, 16'h00FF);
    preload(4'd7, 16'h1234);
    run_op(4'd6, 4'd6, 4'd15, 1'b1, 0, 4'd0);
    n_checks++;
    if (n_wr != 2 || wr_addr[1] !== 4'd0) begin
      n_fail++; $display("FAIL wrap_addr: writes=%0d hi_waddr=%h expected 2/0", n_wr, wr_addr[1]);
    end
    n_checks++;
    if ({rf[15], rf[0]} !== {16'hFE01, 16'h0000}) begin
      n_fail++; $display("FAIL wrap_rf: r15=%h r0=%h expected fe01 0000", rf[15], rf[0]);
    end
    n_checks++;
    if ({rf[6], rf[7]} !== {16'h00FF, 16'h1234}) begin
      n_fail++; $display("FAIL wrap_src: r6=%h r7=%h expected 00ff 1234", rf[6], rf[7]);
    end
  endtask

  task automatic test_start_ignored;
    run_op(4'd1, 4'd2, 4'd8, 1'b0, 5, 4'd9);
    n_checks++;
    if (n_wr != 1 || wr_addr[0] !== 4'd8 || wr_din[0] !== 16'h004B) begin
      n_fail++; $display("FAIL busy_start_wr: writes=%0d waddr=%h din=%h expected 1 8 004b", n_wr, wr_addr[0], wr_din[0]);
    end
    n_checks++;
    if (busy_drop != 0 || rf[9] !== 16'h0000) begin
      n_fail++; $display("FAIL busy_start_side: drops=%0d r9=%h expected 0 0000", busy_drop, rf[9]);
    end
    n_checks++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_queued: busy=%b we=%b expected 0 0", busy, we);
    end
  endtask

  task automatic test_reset_mid;
    int extra_we;
    rs_a = 4'd1; rs_b = 4'd2; rd = 4'd11; wide = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, we, done} !== 3'b000 || raddra !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid: busy/we/done=%b raddra=%h expected 000 0", {busy, we, done}, raddra);
    end
    extra_we = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (we || done || busy) extra_we++;
    end
    n_checks++;
    if (extra_we != 0 || rf[11] !== 16'h0000 || rf[12] !== 16'h0000) begin
      n_fail++; $display("FAIL rst_mid_nowrite: activity=%0d r11=%h r12=%h expected 0 0000 0000", extra_we, rf[11], rf[12]);
    end
    run_op(4'd1, 4'd2, 4'd11, 1'b0, 0, 4'd0);
    n_checks++;
    if (n_wr != 1 || wr_cyc[0] != 18 || rf[11] !== 16'h004B) begin
      n_fail++; $display("FAIL rst_mid_recover: writes=%0d cyc=%0d r11=%h expected 1 18 004b", n_wr, wr_cyc[0], rf[11]);
    end
  endtask

  task automatic test_back_to_back;
    run_op(4'd1, 4'd1, 4'd12, 1'b0, 0, 4'd0);
    run_op(4'd2, 4'd2, 4'd13, 1'b1, 0, 4'd0);
    n_checks++;
    if (n_wr != 2 || wr_cyc[0] != 18 || wr_cyc[1] != 19) begin
      n_fail++; $display("FAIL b2b_timing: writes=%0d cyc0=%0d cyc1=%0d expected 2 18 19", n_wr, wr_cyc[0], wr_cyc[1]);
    end
    n_checks++;
    if ({rf[12], rf[13], rf[14]} !== {16'h0019, 16'h00E1, 16'h0000}) begin
      n_fail++; $display("FAIL b2b_rf: r12=%h r13=%h r14=%h expected 0019 00e1 0000", rf[12], rf[13], rf[14]);
    end
  endtask

  task automatic test_rst_start;
    int act;
    rst = 1'b1; start = 1'b1; rs_a = 4'd5; rs_b = 4'd6; rd = 4'd7; wide = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || raddra !== 4'd0 || raddrb !== 4'd0) begin
      n_fail++; $display("FAIL rst_start: busy=%b ra=%h rb=%h expected 0 0 0", busy, raddra, raddrb);
    end
    act = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (we || busy) act++;
    end
    n_checks++;
    if (act != 0 || rf[7] !== 16'h1234) begin
      n_fail++; $display("FAIL rst_start_idle: activity=%0d r7=%h expected 0 1234", act, rf[7]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_narrow();
    test_wide();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_rst_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mul_unit.md
Name: regfile_mul_unit

Overview:
- Iterative 16x16 unsigned shift-add multiplier sitting beside the 16-entry register file.
- Drives the regfile read ports (raddra/raddrb), captures douta/doutb, computes the product over WIDTH cycles, then writes back through the regfile write port (waddr/din/we).
- Writes the low half to rd; in wide mode also writes the high half to rd+1.
- Sits upstream of the regfile write port and downstream of its read ports, so it both feeds and consumes the regfile.

Parameters:
- WIDTH, 16, data width of operands and of each written half; CALC lasts WIDTH cycles.
- AW, 4, register address width (2**AW registers).

Ports:
- clk     in   1      rising-edge clock; the block's only clock
- rst     in   1      synchronous, active-high reset
- start   in   1      request; sampled only in IDLE
- rs_a    in   AW     source register A index
- rs_b    in   AW     source register B index
- rd      in   AW     destination register index
- wide    in   1      1 = write full 2*WIDTH product (lo to rd, hi to rd+1); 0 = lo only
- busy    out  1      high in every state except IDLE
- done    out  1      one-cycle pulse on the final writeback cycle
- raddra  out  AW     to regfile read port A
- raddrb  out  AW     to regfile read port B
- douta   in   WIDTH  from regfile port A (combinational read)
- doutb   in   WIDTH  from regfile port B (combinational read)
- waddr   out  AW     to regfile write address
- din     out  WIDTH  to regfile write data
- we      out  1      to regfile write enable

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; busy=0, done=0, we=0, waddr=0, din=0, raddra=0, raddrb=0; product, count and latched fields cleared.
- rst has priority over start in the same cycle.
- FSM states: IDLE, FETCH, CALC, WB_LO, WB_HI.
- IDLE:
  - start=1 latches rs_a, rs_b, rd, wide.
  - raddra<=rs_a and raddrb<=rs_b take effect at that same edge.
  - Next state FETCH.
- FETCH (1 cycle): at the closing edge, capture douta into the multiplicand register and doutb into the multiplier register; clear the 2*WIDTH accumulator and count; go to CALC.
- CALC (exactly WIDTH cycles, count 0..WIDTH-1):
  - Each cycle: if multiplier[0], add multiplicand to acc[2W-1:W] with carry; then shift {carry, acc} right by 1.
  - At count==WIDTH-1, go to WB_LO.
- WB_LO (1 cycle): we=1, waddr=rd_l, din=acc[W-1:0].
  - wide_l=0: done=1, next IDLE.
  - wide_l=1: next WB_HI.
- WB_HI (1 cycle): we=1, waddr=(rd_l+1) mod 2**AW, din=acc[2W-1:W], done=1, next IDLE.
- Output decode: we, waddr, din and done are decoded from registered state/datapath only, with no combinational path from inputs. Outside WB states we=0, done=0.
- Latency: edge sampling start = E0; WB_LO occupies the cycle after E0+17 edges (WIDTH=16). Narrow op = 19 cycles start-to-idle; wide op = 20.
- start while busy=1 is ignored and not queued; start is re-sampled only once IDLE is reached.
- A new start may be sampled in the IDLE cycle immediately after done.
- Operands are captured in FETCH, so rd equal to rs_a or rs_b is safe. rs_a==rs_b squares the operand.
- rd=2**AW-1 with wide=1: the high half wraps to register 0.
- Zero operand: still runs the full WIDTH cycles and writes 0.
- Reset mid-operation (any state): return to IDLE at that edge. No further we pulse, no done, and no partial write of the high half.

Decomposition:
- Shared include/package mul_defs: WIDTH/AW defaults and state encodings (S_IDLE=0, S_FETCH=1, S_CALC=2, S_WB_LO=3, S_WB_HI=4, 3 bits).
- One natural sub-module, shift_add_core: multiplicand/multiplier/acc registers, count, and a last-step flag. It has load and step inputs and a product output.
- Control FSM and regfile port drive stay in regfile_mul_unit.

Test Plan:
- Preload r0=3, r1=5. start rs_a=0 rs_b=1 rd=2 wide=0 → single we pulse at the 18th cycle after the start edge, waddr=2, din=0x000F. done pulses in that cycle and r2 reads 0x000F.
- r3=0xFFFF. start rs_a=3 rs_b=3 rd=4 wide=1 → two consecutive writes: r4=0x0001, then r5=0xFFFE. done is high only on the second write.
- r6=0x00FF, r7=0x1234. start rs_a=6 rs_b=6 rd=15 wide=1 → r15=0xFE01, r0=0x0000 (wrap). r6 and r7 unchanged.
- Assert start again at cycle 5 of a running op with different rd → ignored: no extra we and only the original rd written. busy stays high until done.
- rst=1 for one cycle during CALC (count=8) → next cycle busy=0, we=0, done=0, raddra=0. No regfile write occurs; the next start runs normally.
- rst and start both high in IDLE → remains IDLE, busy=0.
